// File: rtl/mining_scheduler_if.sv
// Job, miner-core and result signals of the mining scheduler, grouped into one bundle.
// The scheduler uses the slave view; its environment uses the master view.
interface mining_scheduler_if;
  logic        job_valid;
  logic        job_ready;
  logic [95:0] job_payload;
  logic [7:0]  job_target;

  logic        miner_active;
  logic [95:0] miner_payload;
  logic [7:0]  miner_target;
  logic        miner_terminado;
  logic [31:0] miner_nonce;
  logic [23:0] miner_hash;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_nonce;
  logic [23:0] res_hash;
  logic [3:0]  res_tag;
  logic [31:0] res_cycles;
  logic        res_timeout;

  modport slave (
    input  job_valid, job_payload, job_target,
    input  miner_terminado, miner_nonce, miner_hash,
    input  res_ready,
    output job_ready,
    output miner_active, miner_payload, miner_target,
    output res_valid, res_nonce, res_hash, res_tag, res_cycles, res_timeout
  );

  modport master (
    output job_valid, job_payload, job_target,
    output miner_terminado, miner_nonce, miner_hash,
    output res_ready,
    input  job_ready,
    input  miner_active, miner_payload, miner_target,
    input  res_valid, res_nonce, res_hash, res_tag, res_cycles, res_timeout
  );
endinterface

// File: rtl/mining_scheduler.sv
// Job scheduler for a nonce-search core: queues tagged jobs, runs them one at a time,
// aborts a job after MAX_CYCLES and hands each result downstream with a valid/ready handshake.
module mining_scheduler #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] MAX_CYCLES = 32'd1000000
) (
  input  logic               clk,
  input  logic               reset,
  mining_scheduler_if.slave  bus
);

  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic [95:0] payload;
    logic [7:0]  target;
    logic [3:0]  tag;
  } job_t;

  job_t          mem_q [DEPTH];
  job_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    tag_q, tag_d;
  logic          alive_q;
  logic          push, pop;

  state_t        state_q;
  logic [31:0]   cycles_q;
  logic [31:0]   cycles_inc;
  logic [3:0]    run_tag_q;
  logic          miner_active_q;
  logic [95:0]   miner_payload_q;
  logic [7:0]    miner_target_q;
  logic          res_valid_q;
  logic [31:0]   res_nonce_q;
  logic [23:0]   res_hash_q;
  logic [3:0]    res_tag_q;
  logic [31:0]   res_cycles_q;
  logic          res_timeout_q;

  // alive_q keeps job_ready low during reset even though the empty count would allow a push.
  assign bus.job_ready = alive_q && (count_q < DEPTH_C);
  assign push          = bus.job_valid && bus.job_ready;
  assign pop           = res_valid_q && bus.res_ready;
  assign head          = mem_q[rd_ptr_q];
  assign cycles_inc    = cycles_q + 32'd1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tag_d    = tag_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      tag_d    = tag_q + 4'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
      alive_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
      alive_q  <= 1'b1;
    end
  end

  // NOTE: the job storage is not reset; emptying the pointers and count is enough to discard it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.job_payload, bus.job_target, tag_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cycles_q        <= '0;
      run_tag_q       <= '0;
      miner_active_q  <= 1'b0;
      miner_payload_q <= '0;
      miner_target_q  <= '0;
      res_valid_q     <= 1'b0;
      res_nonce_q     <= '0;
      res_hash_q      <= '0;
      res_tag_q       <= '0;
      res_cycles_q    <= '0;
      res_timeout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q         <= LOAD;
            miner_payload_q <= head.payload;
            miner_target_q  <= head.target;
            run_tag_q       <= head.tag;
            cycles_q        <= '0;
          end
        end
        LOAD: begin
          state_q        <= RUN;
          miner_active_q <= 1'b1;
          cycles_q       <= '0;
        end
        RUN: begin
          cycles_q <= cycles_inc;
          // A find in the same cycle as the timeout still reports the nonce.
          if (bus.miner_terminado) begin
            state_q        <= DONE;
            miner_active_q <= 1'b0;
            res_valid_q    <= 1'b1;
            res_nonce_q    <= bus.miner_nonce;
            res_hash_q     <= bus.miner_hash;
            res_tag_q      <= run_tag_q;
            res_cycles_q   <= cycles_inc;
            res_timeout_q  <= 1'b0;
          end else if (cycles_inc == MAX_CYCLES) begin
            state_q        <= DONE;
            miner_active_q <= 1'b0;
            res_valid_q    <= 1'b1;
            res_nonce_q    <= '0;
            res_hash_q     <= '0;
            res_tag_q      <= run_tag_q;
            res_cycles_q   <= MAX_CYCLES;
            res_timeout_q  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q         <= IDLE;
            res_valid_q     <= 1'b0;
            miner_payload_q <= '0;
            miner_target_q  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.miner_active  = miner_active_q;
  assign bus.miner_payload = miner_payload_q;
  assign bus.miner_target  = miner_target_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_nonce     = res_nonce_q;
  assign bus.res_hash      = res_hash_q;
  assign bus.res_tag       = res_tag_q;
  assign bus.res_cycles    = res_cycles_q;
  assign bus.res_timeout   = res_timeout_q;

endmodule

// File: tb/tb_mining_scheduler.sv
// Scoreboard bench for mining_scheduler: one instance at the default timeout, one with MAX_CYCLES=16.
// Expected results are queued when a job is accepted and popped by per-instance monitors.
module tb_mining_scheduler;

  localparam int MAIN_MAX = 1000000;
  localparam int TO_MAX   = 16;

  typedef struct packed {
    logic [31:0] nonce;
    logic [23:0] hash;
    logic [3:0]  tag;
    logic [31:0] cycles;
    logic        timeout;
  } res_t;

  typedef struct {
    int          lat;
    logic [31:0] nonce;
    logic [23:0] hash;
  } core_t;

  logic clk;
  logic reset;

  mining_scheduler_if m ();
  mining_scheduler_if b ();

  mining_scheduler #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  mining_scheduler #(.DEPTH(4), .MAX_CYCLES(32'd16)) dut_to (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  res_t  exp_q  [$];
  res_t  exp_q2 [$];
  core_t core_q [$];
  core_t core_q2[$];
  logic [3:0] exp_tag  = '0;
  logic [3:0] exp_tag2 = '0;

  bit   core_hold = 0;
  int   n_pops    = 0;
  int   res_cnt   = 0;
  bit   rv_seen   = 0;
  logic [3:0] last_tag = '0;
  int   pops_at_accept = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare_res(input string who, input res_t e, input res_t g);
    check({who, "_nonce"},   g.nonce,   e.nonce);
    check({who, "_hash"},    g.hash,    e.hash);
    check({who, "_tag"},     g.tag,     e.tag);
    check({who, "_cycles"},  g.cycles,  e.cycles);
    check({who, "_timeout"}, g.timeout, e.timeout);
  endtask

  // Core models: raise terminado on the lat-th RUN cycle of each job (lat 0 = never finishes).
  core_t cur_m, cur_b;
  int    cnt_m = 0, cnt_b = 0;
  bit    was_m = 0, was_b = 0;

  always @(negedge clk) begin
    if (m.miner_active === 1'b1) begin
      if (!was_m) begin
        cnt_m = 0;
        if (core_q.size() > 0) cur_m = core_q.pop_front();
        else cur_m = '{lat: 0, nonce: '0, hash: '0};
      end
      cnt_m++;
      m.miner_nonce     = cur_m.nonce;
      m.miner_hash      = cur_m.hash;
      m.miner_terminado = (cur_m.lat != 0) && (cnt_m == cur_m.lat);
    end else begin
      cnt_m = 0;
      m.miner_terminado = core_hold;
      if (!core_hold) begin
        m.miner_nonce = '0;
        m.miner_hash  = '0;
      end
    end
    was_m = (m.miner_active === 1'b1);
  end

  always @(negedge clk) begin
    if (b.miner_active === 1'b1) begin
      if (!was_b) begin
        cnt_b = 0;
        if (core_q2.size() > 0) cur_b = core_q2.pop_front();
        else cur_b = '{lat: 0, nonce: '0, hash: '0};
      end
      cnt_b++;
      b.miner_nonce     = cur_b.nonce;
      b.miner_hash      = cur_b.hash;
      b.miner_terminado = (cur_b.lat != 0) && (cnt_b == cur_b.lat);
    end else begin
      cnt_b = 0;
      b.miner_terminado = 1'b0;
      b.miner_nonce     = '0;
      b.miner_hash      = '0;
    end
    was_b = (b.miner_active === 1'b1);
  end

  // Monitors: compare on every result handshake and check fields hold while stalled.
  bit   held_m = 0, held_b = 0;
  res_t snap_m, snap_b;

  always @(negedge clk) begin
    res_t g, e;
    g = {m.res_nonce, m.res_hash, m.res_tag, m.res_cycles, m.res_timeout};
    if (m.res_valid === 1'b1) begin
      rv_seen = 1;
      if (held_m) check("res_stable", g, snap_m);
      if (m.res_ready === 1'b1) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", m.res_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          compare_res("res", e, g);
          last_tag = m.res_tag;
          res_cnt++;
        end
        held_m = 0;
      end else begin
        held_m = 1;
        snap_m = g;
      end
    end else begin
      held_m = 0;
    end
  end

  always @(negedge clk) begin
    res_t g, e;
    g = {b.res_nonce, b.res_hash, b.res_tag, b.res_cycles, b.res_timeout};
    if (b.res_valid === 1'b1) begin
      if (held_b) check("to_res_stable", g, snap_b);
      if (b.res_ready === 1'b1) begin
        if (exp_q2.size() == 0) begin
          check("to_unexpected_result", b.res_valid, 1'b0);
        end else begin
          e = exp_q2.pop_front();
          compare_res("to_res", e, g);
        end
        held_b = 0;
      end else begin
        held_b = 1;
        snap_b = g;
      end
    end else begin
      held_b = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_job(input int sel, input logic [95:0] pl, input logic [7:0] tg,
                          input int lat, input logic [31:0] nonce, input logic [23:0] hash);
    bit   accepted;
    logic rdy;
    res_t e;
    int   maxc;
    maxc = (sel == 0) ? MAIN_MAX : TO_MAX;
    if (sel == 0) begin
      m.job_valid = 1'b1; m.job_payload = pl; m.job_target = tg;
    end else begin
      b.job_valid = 1'b1; b.job_payload = pl; b.job_target = tg;
    end
    accepted = 0;
    for (int k = 0; k < 400 && !accepted; k++) begin
      rdy = (sel == 0) ? m.job_ready : b.job_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) accepted = 1;
    end
    if (sel == 0) m.job_valid = 1'b0;
    else b.job_valid = 1'b0;
    if (!accepted) begin
      check("push_timeout", 1'b0, 1'b1);
    end else begin
      e.tag = (sel == 0) ? exp_tag : exp_tag2;
      if (lat != 0 && lat <= maxc) begin
        e.nonce = nonce; e.hash = hash; e.cycles = lat; e.timeout = 1'b0;
      end else begin
        e.nonce = '0; e.hash = '0; e.cycles = maxc; e.timeout = 1'b1;
      end
      if (sel == 0) begin
        exp_q.push_back(e);
        core_q.push_back('{lat: lat, nonce: nonce, hash: hash});
        exp_tag = exp_tag + 4'd1;
        pops_at_accept = n_pops;
      end else begin
        exp_q2.push_back(e);
        core_q2.push_back('{lat: lat, nonce: nonce, hash: hash});
        exp_tag2 = exp_tag2 + 4'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete(); exp_q2.delete(); core_q.delete(); core_q2.delete();
    exp_tag = '0; exp_tag2 = '0; n_pops = 0;
    @(posedge clk); @(negedge clk);
    check("rst_job_ready",     m.job_ready,     1'b0);
    check("rst_miner_active",  m.miner_active,  1'b0);
    check("rst_res_valid",     m.res_valid,     1'b0);
    check("rst_miner_payload", m.miner_payload, 96'h0);
    check("rst_to_job_ready",  b.job_ready,     1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_after_reset", m.job_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_q2.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit act;
    reset = 1'b1;
    m.job_valid = 1'b0; m.job_payload = '0; m.job_target = '0; m.res_ready = 1'b1;
    b.job_valid = 1'b0; b.job_payload = '0; b.job_target = '0; b.res_ready = 1'b1;

    do_reset();

    // Single job found after 37 RUN cycles; watch IDLE -> LOAD -> RUN on the way.
    push_job(0, 96'h397d9f2f40ca9e6c6b1f3324, 8'h0a, 37, 32'h0000_1234, 24'h00_0abc);
    @(negedge clk);
    check("idle_payload_zero", m.miner_payload, 96'h0);
    check("idle_active_low",   m.miner_active,  1'b0);
    @(negedge clk);
    check("load_payload",      m.miner_payload, 96'h397d9f2f40ca9e6c6b1f3324);
    check("load_target",       m.miner_target,  8'h0a);
    check("load_active_low",   m.miner_active,  1'b0);
    @(negedge clk);
    check("run_active_high",   m.miner_active,  1'b1);
    drain();

    // Five back-to-back jobs against a depth-4 FIFO with the result side stalled.
    do_reset();
    m.res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_job(0, {32'hA000_0000 + i, 64'h0}, 8'(i), 3, 32'h100 + i, 24'h200 + 24'(i));
    check("full_ready_low", m.job_ready, 1'b0);
    fork
      push_job(0, {32'hA000_0004, 64'h0}, 8'd4, 3, 32'h104, 24'h204);
      begin
        repeat (20) @(posedge clk);
        #1;
        check("ready_low_while_full", m.job_ready, 1'b0);
        m.res_ready = 1'b1;
      end
    join
    check("fifth_after_first_pop", pops_at_accept, 1);
    drain();

    // Timeout instance: never finishes, finishes exactly at MAX_CYCLES, finishes one earlier.
    push_job(1, 96'h1, 8'h01, 0,  32'hdead_0001, 24'hbee001);
    push_job(1, 96'h2, 8'h02, 16, 32'hdead_0002, 24'hbee002);
    push_job(1, 96'h3, 8'h03, 15, 32'hdead_0003, 24'hbee003);
    drain();

    // Stale terminado held through DONE/IDLE/LOAD must not capture the next job early.
    core_hold = 1;
    push_job(0, 96'hC1, 8'h11, 4, 32'hCAFE_0001, 24'h0C0001);
    push_job(0, 96'hC2, 8'h12, 6, 32'hCAFE_0002, 24'h0C0002);
    drain();
    core_hold = 0;

    // Reset while a job is running with two more queued.
    push_job(0, 96'hD1, 8'h21, 0, 32'h0, 24'h0);
    push_job(0, 96'hD2, 8'h22, 0, 32'h0, 24'h0);
    push_job(0, 96'hD3, 8'h23, 0, 32'h0, 24'h0);
    act = 0;
    for (int k = 0; k < 30 && !act; k++) begin
      @(negedge clk);
      if (m.miner_active === 1'b1) act = 1;
    end
    check("reach_run_before_reset", act, 1'b1);
    repeat (9) @(posedge clk);
    do_reset();
    rv_seen = 0;
    repeat (20) @(negedge clk);
    check("no_result_after_reset", rv_seen, 1'b0);
    @(posedge clk); #1;

    // Seventeen jobs: the tag wraps back to 0 on the last one.
    res_cnt = 0;
    for (int i = 0; i < 17; i++)
      push_job(0, {32'hE000_0000 + i, 64'h5}, 8'h30, 2, 32'h9000 + i, 24'h9000 + 24'(i));
    drain();
    check("wrap_result_count", res_cnt, 17);
    check("wrap_17th_tag", last_tag, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
